// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared scalar aliases, constants and pipeline-control types.
// Rev 1.0
`default_nettype none

package pipe_ctrl_pkg;

   typedef logic        u1;
   typedef logic [63:0] u64;

   localparam u1 ON  = 1'b1;
   localparam u1 OFF = 1'b0;

   localparam int unsigned CNT_W_DEF = 32;
   typedef logic [CNT_W_DEF-1:0] cnt_t;

   typedef enum logic [0:0] {
      CTRL_IDLE = 1'b0,
      CTRL_DROP = 1'b1
   } ctrl_state_t;

   typedef struct packed {
      logic stall;
      logic flush;
   } stage_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_perf_cnt.sv
// perf_cnt: enable-gated free-running counter that wraps at 2^W.
// Rev 1.0
`default_nettype none

module perf_cnt #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);

   localparam logic [W-1:0] C_ONE = W'(1);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= cnt_q + C_ONE;
      end
   end

   assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: prioritised stall/flush/redirect controller for the five-stage pipeline.
// Rev 1.0
`default_nettype none

module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             load_stall,
   input  logic             i_busy,
   input  logic             i_data_ok,
   input  logic             d_wait,
   input  logic             mdu_busy,
   input  logic             redirect_valid,
   input  logic [63:0]      redirect_target,
   output logic             stallF,
   output logic             stallD,
   output logic             stallE,
   output logic             stallM,
   output logic             flushD,
   output logic             flushE,
   output logic             flushM,
   output logic             flushW,
   output logic             pc_redirect,
   output logic [63:0]      pc_target,
   output logic             fetch_discard,
   output logic [CNT_W-1:0] cnt_load_stall,
   output logic [CNT_W-1:0] cnt_redirect
);

   ctrl_state_t state_q, state_d;
   u64          tgt_q, tgt_d;

   u1           stall_f;
   u1           flush_w;
   stage_ctrl_t ctrl_id, ctrl_ex, ctrl_mem;
   u1           inc_ls, inc_rd;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= CTRL_IDLE;
         tgt_q   <= '0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      tgt_d         = tgt_q;
      stall_f       = OFF;
      flush_w       = OFF;
      ctrl_id       = '0;
      ctrl_ex       = '0;
      ctrl_mem      = '0;
      pc_redirect   = OFF;
      pc_target     = '0;
      fetch_discard = OFF;
      inc_ls        = OFF;
      inc_rd        = OFF;

      case (state_q)
         CTRL_IDLE: begin
            if (d_wait) begin
               stall_f        = ON;
               ctrl_id.stall  = ON;
               ctrl_ex.stall  = ON;
               ctrl_mem.stall = ON;
               flush_w        = ON;
            end else if (mdu_busy) begin
               stall_f        = ON;
               ctrl_id.stall  = ON;
               ctrl_ex.stall  = ON;
               ctrl_mem.flush = ON;
            end else if (redirect_valid) begin
               ctrl_id.flush = ON;
               ctrl_ex.flush = ON;
               inc_rd        = ON;
               if (!i_busy || i_data_ok) begin
                  pc_redirect   = ON;
                  pc_target     = redirect_target;
                  fetch_discard = i_busy;
               end else begin
                  // Fetch still in flight: park the target until its response is dropped.
                  tgt_d   = redirect_target;
                  state_d = CTRL_DROP;
                  stall_f = ON;
               end
            end else if (load_stall) begin
               stall_f       = ON;
               ctrl_id.stall = ON;
               ctrl_ex.flush = ON;
               inc_ls        = ON;
            end else if (i_busy && !i_data_ok) begin
               stall_f       = ON;
               ctrl_id.flush = ON;
            end
         end

         CTRL_DROP: begin
            stall_f = ON;
            if (d_wait) begin
               ctrl_id.stall  = ON;
               ctrl_ex.stall  = ON;
               ctrl_mem.stall = ON;
               flush_w        = ON;
            end else if (mdu_busy) begin
               ctrl_id.stall  = ON;
               ctrl_ex.stall  = ON;
               ctrl_mem.flush = ON;
            end
            ctrl_id.flush = ON;
            if (i_data_ok) begin
               fetch_discard = ON;
               pc_redirect   = ON;
               pc_target     = tgt_q;
               state_d       = CTRL_IDLE;
            end
         end

         default: state_d = CTRL_IDLE;
      endcase

      ctrl_id.flush  = ctrl_id.flush  & ~ctrl_id.stall;
      ctrl_ex.flush  = ctrl_ex.flush  & ~ctrl_ex.stall;
      ctrl_mem.flush = ctrl_mem.flush & ~ctrl_mem.stall;
   end

   assign stallF = stall_f;
   assign stallD = ctrl_id.stall;
   assign stallE = ctrl_ex.stall;
   assign stallM = ctrl_mem.stall;
   assign flushD = ctrl_id.flush;
   assign flushE = ctrl_ex.flush;
   assign flushM = ctrl_mem.flush;
   assign flushW = flush_w;

   perf_cnt #(.W(CNT_W)) u_cnt_load_stall (
      .clk    (clk),
      .resetn (resetn),
      .en_i   (inc_ls),
      .cnt_o  (cnt_load_stall)
   );

   perf_cnt #(.W(CNT_W)) u_cnt_redirect (
      .clk    (clk),
      .resetn (resetn),
      .en_i   (inc_rd),
      .cnt_o  (cnt_redirect)
   );

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed-vector scoreboard bench for pipe_ctrl.
// Rev 1.0
`default_nettype none

module tb_pipe_ctrl;
   import pipe_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        load_stall = 1'b0, i_busy = 1'b0, i_data_ok = 1'b0;
   logic        d_wait = 1'b0, mdu_busy = 1'b0, redirect_valid = 1'b0;
   logic [63:0] redirect_target = '0;

   logic        stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW;
   logic        pc_redirect, fetch_discard;
   logic [63:0] pc_target;
   logic [31:0] cnt_load_stall, cnt_redirect;

   logic        s_stallF, s_stallD, s_stallE, s_stallM, s_flushD, s_flushE, s_flushM, s_flushW;
   logic        s_pc_redirect, s_fetch_discard;
   logic [63:0] s_pc_target;
   logic [3:0]  s_cnt_load_stall, s_cnt_redirect;

   always #5 clk = ~clk;

   pipe_ctrl #(.CNT_W(32)) dut (
      .clk(clk), .resetn(resetn), .load_stall(load_stall), .i_busy(i_busy),
      .i_data_ok(i_data_ok), .d_wait(d_wait), .mdu_busy(mdu_busy),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
      .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
      .pc_redirect(pc_redirect), .pc_target(pc_target), .fetch_discard(fetch_discard),
      .cnt_load_stall(cnt_load_stall), .cnt_redirect(cnt_redirect)
   );

   // Narrow-counter twin on the same inputs so wraparound is reachable quickly.
   pipe_ctrl #(.CNT_W(4)) dut_small (
      .clk(clk), .resetn(resetn), .load_stall(load_stall), .i_busy(i_busy),
      .i_data_ok(i_data_ok), .d_wait(d_wait), .mdu_busy(mdu_busy),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .stallF(s_stallF), .stallD(s_stallD), .stallE(s_stallE), .stallM(s_stallM),
      .flushD(s_flushD), .flushE(s_flushE), .flushM(s_flushM), .flushW(s_flushW),
      .pc_redirect(s_pc_redirect), .pc_target(s_pc_target), .fetch_discard(s_fetch_discard),
      .cnt_load_stall(s_cnt_load_stall), .cnt_redirect(s_cnt_redirect)
   );

   typedef struct {
      int          idx;
      logic [7:0]  ctl;
      logic        pr;
      logic        fd;
      logic [63:0] tgt;
      logic [31:0] cls;
      logic [31:0] crd;
      logic [3:0]  crd_small;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_vec = 0;

   task automatic chk(input string name, input int idx, input logic [63:0] got,
                      input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s vec=%0d got=0x%0h expected=0x%0h", name, idx, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() != 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("ctl", e.idx, 64'({stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW}),
             64'(e.ctl));
         chk("pc_redirect", e.idx, 64'(pc_redirect), 64'(e.pr));
         chk("fetch_discard", e.idx, 64'(fetch_discard), 64'(e.fd));
         chk("pc_target", e.idx, pc_target, e.tgt);
         chk("cnt_load_stall", e.idx, 64'(cnt_load_stall), 64'(e.cls));
         chk("cnt_redirect", e.idx, 64'(cnt_redirect), 64'(e.crd));
         chk("cnt_redirect_w4", e.idx, 64'(s_cnt_redirect), 64'(e.crd_small));
      end
   end

   always @(negedge clk) begin
      if (resetn && dut.state_q == CTRL_DROP)
         assert (!redirect_valid) else $error("redirect_valid asserted while in DROP");
   end

   // ctl order: stallF stallD stallE stallM flushD flushE flushM flushW
   task automatic step(input logic rn, input logic ls, input logic ib, input logic ok,
                       input logic dw, input logic mb, input logic rv, input logic [63:0] tg,
                       input logic [7:0] ctl, input logic pr, input logic fd,
                       input logic [63:0] et, input logic [31:0] cls, input logic [31:0] crd);
      exp_t e;
      @(posedge clk);
      #1;
      resetn = rn; load_stall = ls; i_busy = ib; i_data_ok = ok;
      d_wait = dw; mdu_busy = mb; redirect_valid = rv; redirect_target = tg;
      e.idx = n_vec; e.ctl = ctl; e.pr = pr; e.fd = fd; e.tgt = et;
      e.cls = cls; e.crd = crd; e.crd_small = crd[3:0];
      sb.push_back(e);
      n_vec++;
   endtask

   initial begin
      //    rn ls ib ok dw mb rv target         ctl           pr fd exp_tgt        cls crd
      step(0, 0, 0, 0, 0, 0, 0, 64'h0,         8'b0000_0000, 0, 0, 64'h0,         0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 64'h0,         8'b0000_0000, 0, 0, 64'h0,         0, 0);
      step(1, 1, 0, 0, 0, 0, 0, 64'h0,         8'b1100_0100, 0, 0, 64'h0,         0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 64'h0,         8'b0000_0000, 0, 0, 64'h0,         1, 0);
      step(1, 1, 0, 0, 0, 0, 1, 64'h8000_0040, 8'b0000_1100, 1, 0, 64'h8000_0040, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0, 64'h0,         8'b0000_0000, 0, 0, 64'h0,         1, 1);
      step(1, 1, 0, 0, 1, 1, 1, 64'h8000_0044, 8'b1111_0001, 0, 0, 64'h0,         1, 1);
      step(1, 1, 0, 0, 0, 1, 1, 64'h8000_0044, 8'b1110_0010, 0, 0, 64'h0,         1, 1);
      step(1, 0, 0, 0, 0, 0, 0, 64'h0,         8'b0000_0000, 0, 0, 64'h0,         1, 1);
      step(1, 0, 1, 1, 0, 0, 1, 64'h8000_0080, 8'b0000_1100, 1, 1, 64'h8000_0080, 1, 1);
      step(1, 0, 1, 0, 0, 0, 0, 64'h0,         8'b1000_1000, 0, 0, 64'h0,         1, 2);
      step(1, 0, 1, 0, 0, 0, 1, 64'h8000_0100, 8'b1000_1100, 0, 0, 64'h0,         1, 2);
      step(1, 0, 1, 0, 0, 0, 0, 64'h0,         8'b1000_1000, 0, 0, 64'h0,         1, 3);
      step(1, 1, 1, 0, 0, 0, 0, 64'h0,         8'b1000_1000, 0, 0, 64'h0,         1, 3);
      step(1, 0, 1, 0, 0, 1, 0, 64'h0,         8'b1110_0010, 0, 0, 64'h0,         1, 3);
      step(1, 0, 1, 1, 0, 0, 0, 64'h0,         8'b1000_1000, 1, 1, 64'h8000_0100, 1, 3);
      step(1, 0, 0, 0, 0, 0, 0, 64'h0,         8'b0000_0000, 0, 0, 64'h0,         1, 3);
      step(1, 0, 0, 0, 1, 0, 0, 64'h0,         8'b1111_0001, 0, 0, 64'h0,         1, 3);
      step(1, 0, 1, 0, 0, 0, 1, 64'h8000_0200, 8'b1000_1100, 0, 0, 64'h0,         1, 3);
      step(1, 0, 1, 0, 0, 0, 0, 64'h0,         8'b1000_1000, 0, 0, 64'h0,         1, 4);
      step(0, 0, 1, 1, 0, 0, 0, 64'h0,         8'b0000_0000, 0, 0, 64'h0,         0, 0);
      step(1, 0, 1, 1, 0, 0, 0, 64'h0,         8'b0000_0000, 0, 0, 64'h0,         0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 64'h0,         8'b0000_0000, 0, 0, 64'h0,         0, 0);
      for (int k = 0; k < 17; k++) begin
         step(1, 0, 0, 0, 0, 0, 1, 64'h1000 + 64'(4 * k), 8'b0000_1100, 1, 0,
              64'h1000 + 64'(4 * k), 0, 32'(k));
      end
      step(1, 0, 0, 0, 0, 0, 0, 64'h0,         8'b0000_0000, 0, 0, 64'h0,         0, 17);

      for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain pending=%0d expected=0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central hazard controller for the five-stage RISC-V pipeline. It merges these inputs into one prioritised set of per-stage stall and flush controls:
- the load-use stall flag,
- fetch and data-memory handshake waits,
- multi-cycle MDU busy,
- execute-stage branch/jump redirects.

It also sequences redirects that arrive while an instruction fetch is in flight: it discards the stale response and then steers the PC. Two 32-bit performance counters record load-use stall cycles and accepted redirects.

## Interface
Parameters:
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  pipeline clock.
- resetn  in  1  reset; asynchronous, active-low.
- load_stall  in  1  load-use hazard flag from the decode-stage detector.
- i_busy  in  1  fetch request outstanding this cycle.
- i_data_ok  in  1  fetch response valid this cycle; meaningful only when i_busy=1.
- d_wait  in  1  memory-stage data request outstanding and not yet ok.
- mdu_busy  in  1  multi-cycle mul/div occupying execute.
- redirect_valid  in  1  execute resolved a taken branch, a jump, or a mispredict.
- redirect_target  in  64  correct next PC (u64).
- stallF, stallD, stallE, stallM  out  1 each  hold PC, F/D, D/E and E/M registers respectively.
- flushD, flushE, flushM, flushW  out  1 each  load a bubble into F/D, D/E, E/M and M/W respectively.
- pc_redirect  out  1  PC register loads pc_target this cycle.
- pc_target  out  64  redirect PC.
- fetch_discard  out  1  drop the current fetch response; it must not enter F/D.
- cnt_load_stall  out  CNT_W  load-use stall cycles, wrapping.
- cnt_redirect  out  CNT_W  accepted redirects, wrapping.

## Operation
- The FSM has two states: IDLE and DROP. The state, the latched target and the counters are the only registers.
- In IDLE, the first matching rule applies and lower-priority rules are ignored that cycle.
  - d_wait: stallF, stallD, stallE and stallM=1; flushW=1. Redirect is not accepted.
  - mdu_busy: stallF, stallD and stallE=1; flushM=1.
  - redirect_valid (accept): flushD=1, flushE=1, cnt_redirect+1.
    - If !i_busy: pc_redirect=1, pc_target=redirect_target.
    - If i_busy & i_data_ok: pc_redirect=1, pc_target=redirect_target, fetch_discard=1.
    - If i_busy & !i_data_ok: latch redirect_target, go to DROP, stallF=1, pc_redirect=0.
  - load_stall: stallF=1, stallD=1, flushE=1, cnt_load_stall+1. A redirect overrides this rule because it kills the stalled instruction.
  - i_busy & !i_data_ok: stallF=1, flushD=1 (fetch bubble).
  - Otherwise all outputs are 0.
- In DROP:
  - stallF=1 every cycle.
  - d_wait and mdu_busy still apply their stall/flush rules above.
  - flushD=1 when stallD=0.
  - On i_data_ok: fetch_discard=1, pc_redirect=1, pc_target=latched target, next state IDLE.
  - redirect_valid in DROP is illegal, because execute is empty. It is ignored and a bench assertion fires.
- Stall beats flush on the same register: flushX is forced to 0 whenever stallX=1.
- pc_target reads 0 whenever pc_redirect=0.
- Counters wrap at 2^CNT_W. A counter event during d_wait or mdu_busy is not counted, because those rules pre-empt it.

## Timing
- All stall, flush, pc_redirect and fetch_discard outputs are combinational from the inputs and the current state, valid in the same cycle.
- The redirect path in IDLE has zero added latency.
- In DROP, the redirect is delayed until the in-flight fetch returns: pc_redirect coincides with that i_data_ok. The fetch unit starts the new request at the target on the next edge.
- On an accepted redirect, the counter and state update at the next rising clk.
- Reset (asynchronous, active-low): state=IDLE, latched target=0, both counters=0. With all inputs at 0, every output is 0.
- Reset during DROP abandons the pending redirect. The restarted pipeline fetches from the reset PC.

## Structure
- Package common supplies u1, u64 and the ON/OFF constants. Add a CNT_W-wide counter alias there.
- Package pipes gains ctrl_state_t (CTRL_IDLE, CTRL_DROP) and a packed stage_ctrl_t struct {stall, flush}, one per stage, for downstream wiring.
- The load-use detector stays a separate upstream module feeding load_stall.
- One sub-module is natural: perf_cnt, an enable-plus-wrap counter instantiated twice.

## Test plan
- Load-use: load_stall=1 for 1 cycle, all else 0 -> stallF=stallD=flushE=1, no other outputs; cnt_load_stall 0->1.
- Redirect beats load-use: redirect_valid=1, load_stall=1, redirect_target=0x8000_0040, i_busy=0 -> pc_redirect=1, pc_target=0x8000_0040, flushD=flushE=1, stallD=0; cnt_redirect=1 and cnt_load_stall=0.
- Redirect during fetch: redirect_valid=1 with i_busy=1, i_data_ok=0, target 0x8000_0100; i_data_ok arrives 3 cycles later -> stallF=1 for all 4 cycles, pc_redirect=0 until the i_data_ok cycle, then pc_redirect=1, fetch_discard=1, pc_target=0x8000_0100, state back to IDLE.
- Memory wait dominates: d_wait=1 with mdu_busy=1, redirect_valid=1 and load_stall=1 -> stallF/D/E/M=1, flushW=1, pc_redirect=0, counters unchanged; when d_wait drops, mdu rule applies (stallF/D/E=1, flushM=1).
- Reset mid-DROP: enter DROP, assert resetn=0 asynchronously -> state IDLE and counters 0 immediately, no pc_redirect after release, even when i_data_ok follows.
- Counter wrap: force cnt_redirect to 0xFFFF_FFFF, accept one redirect -> 0x0000_0000.
